// File: rtl/jtag_axi_pkg.sv
// Shared AXI encodings, FSM state type and response helpers for the JTAG-AXI SRAM slave.
package jtag_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_8B = 3'b011;

  typedef enum logic [2:0] {
    StIdle,
    StWrData,
    StWrResp,
    StRdReq,
    StRdCap,
    StRdData
  } state_e;

  // Severity order is DECERR > SLVERR > OKAY.
  function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
    if (a == RESP_DECERR || b == RESP_DECERR) return RESP_DECERR;
    if (a == RESP_SLVERR || b == RESP_SLVERR) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  function automatic logic req_err(input logic [2:0] size, input logic [1:0] burst,
                                   input logic [2:0] addr_lsb);
    return (size != SIZE_8B) || (burst != BURST_FIXED && burst != BURST_INCR) ||
           (addr_lsb != 3'b000);
  endfunction

endpackage

// File: rtl/jtag_axi_sram_slave_if.sv
// AXI4 channel bundle between the jtag_axi master and the SRAM slave.
interface jtag_axi_sram_slave_if;
  logic        awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic        bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic        rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/jtag_axi_beat_addr.sv
// Per-burst address and beat tracker: yields the SRAM word index, range status and last flag.
module jtag_axi_beat_addr
  import jtag_axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned MEM_AW    = $clog2(MEM_WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              advance_i,
  input  logic [31:0]       addr_i,
  input  logic [7:0]        len_i,
  input  logic [1:0]        burst_i,
  output logic [MEM_AW-1:0] word_o,
  output logic              in_range_o,
  output logic              last_o
);
  localparam logic [32:0] SpanBytes = 33'(MEM_WORDS) << 3;

  logic [31:0] addr_q;
  logic [7:0]  len_q, beat_q;
  logic [1:0]  burst_q;
  logic [32:0] offset;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      burst_q <= BURST_FIXED;
    end else if (load_i) begin
      addr_q  <= addr_i;
      len_q   <= len_i;
      beat_q  <= '0;
      burst_q <= burst_i;
    end else if (advance_i) begin
      if (burst_q == BURST_INCR) addr_q <= addr_q + 32'd8;
      // Saturate so over-long write bursts cannot wrap back to beat 0.
      if (beat_q != 8'hFF) beat_q <= beat_q + 8'd1;
    end
  end

  assign offset     = {1'b0, addr_q} - {1'b0, BASE_ADDR};
  assign in_range_o = !offset[32] && (offset < SpanBytes);
  assign word_o     = offset[MEM_AW+2:3];
  assign last_o     = (beat_q == len_q);

endmodule

// File: rtl/jtag_axi_sram_slave.sv
// AXI4 slave bridging the JTAG debug master onto a single-port, 1-cycle-latency 64-bit SRAM.
module jtag_axi_sram_slave
  import jtag_axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned MEM_AW    = $clog2(MEM_WORDS)
) (
  input  logic                 aclk,
  input  logic                 areset,
  jtag_axi_sram_slave_if.slave s_axi,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [MEM_AW-1:0]    mem_addr,
  output logic [63:0]          mem_wdata,
  output logic [7:0]           mem_wstrb,
  input  logic [63:0]          mem_rdata
);
  state_e      state_q;
  logic        rd_first_q, wr_slv_q, rd_slv_q, awid_q, arid_q;
  logic        bvalid_q, rvalid_q, rlast_q;
  logic [1:0]  bresp_q, rresp_q;
  logic [63:0] rdata_q;

  logic              idle, aw_hs, ar_hs, wr_adv, rd_adv;
  logic [MEM_AW-1:0] wr_word, rd_word;
  logic              wr_in_range, rd_in_range, wr_last, rd_last, wr_ok, rd_ok;
  logic [1:0]        wr_beat_resp, rd_beat_resp;

  assign idle          = (state_q == StIdle);
  assign s_axi.awready = idle && s_axi.awvalid && (!s_axi.arvalid || !rd_first_q);
  assign s_axi.arready = idle && s_axi.arvalid && (!s_axi.awvalid || rd_first_q);
  assign aw_hs         = s_axi.awvalid && s_axi.awready;
  assign ar_hs         = s_axi.arvalid && s_axi.arready;
  assign wr_adv        = (state_q == StWrData) && s_axi.wvalid;
  assign rd_adv        = (state_q == StRdData) && s_axi.rready && !rlast_q;

  jtag_axi_beat_addr #(.BASE_ADDR(BASE_ADDR), .MEM_WORDS(MEM_WORDS), .MEM_AW(MEM_AW)) u_wr_addr (
    .clk_i      (aclk),
    .rst_i      (areset),
    .load_i     (aw_hs),
    .advance_i  (wr_adv),
    .addr_i     (s_axi.awaddr),
    .len_i      (s_axi.awlen),
    .burst_i    (s_axi.awburst),
    .word_o     (wr_word),
    .in_range_o (wr_in_range),
    .last_o     (wr_last)
  );

  jtag_axi_beat_addr #(.BASE_ADDR(BASE_ADDR), .MEM_WORDS(MEM_WORDS), .MEM_AW(MEM_AW)) u_rd_addr (
    .clk_i      (aclk),
    .rst_i      (areset),
    .load_i     (ar_hs),
    .advance_i  (rd_adv),
    .addr_i     (s_axi.araddr),
    .len_i      (s_axi.arlen),
    .burst_i    (s_axi.arburst),
    .word_o     (rd_word),
    .in_range_o (rd_in_range),
    .last_o     (rd_last)
  );

  assign wr_ok        = !wr_slv_q && wr_in_range;
  assign rd_ok        = !rd_slv_q && rd_in_range;
  assign wr_beat_resp = wr_slv_q ? RESP_SLVERR : (wr_in_range ? RESP_OKAY : RESP_DECERR);
  assign rd_beat_resp = rd_slv_q ? RESP_SLVERR : (rd_in_range ? RESP_OKAY : RESP_DECERR);

  assign mem_we    = wr_adv && wr_ok;
  assign mem_en    = mem_we || ((state_q == StRdReq) && rd_ok);
  assign mem_addr  = (state_q == StWrData) ? wr_word : rd_word;
  assign mem_wdata = s_axi.wdata;
  assign mem_wstrb = s_axi.wstrb;

  assign s_axi.wready = (state_q == StWrData);
  assign s_axi.bid    = awid_q;
  assign s_axi.bresp  = bresp_q;
  assign s_axi.bvalid = bvalid_q;
  assign s_axi.rid    = arid_q;
  assign s_axi.rdata  = rdata_q;
  assign s_axi.rresp  = rresp_q;
  assign s_axi.rlast  = rlast_q;
  assign s_axi.rvalid = rvalid_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= StIdle;
      rd_first_q <= 1'b1;
      wr_slv_q   <= 1'b0;
      rd_slv_q   <= 1'b0;
      awid_q     <= 1'b0;
      arid_q     <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rlast_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Priority only flips when both channels contended for the grant.
          if (ar_hs) begin
            arid_q   <= s_axi.arid;
            rd_slv_q <= req_err(s_axi.arsize, s_axi.arburst, s_axi.araddr[2:0]);
            if (s_axi.awvalid) rd_first_q <= 1'b0;
            state_q  <= StRdReq;
          end else if (aw_hs) begin
            awid_q   <= s_axi.awid;
            wr_slv_q <= req_err(s_axi.awsize, s_axi.awburst, s_axi.awaddr[2:0]);
            bresp_q  <= RESP_OKAY;
            if (s_axi.arvalid) rd_first_q <= 1'b1;
            state_q  <= StWrData;
          end
        end
        StWrData: begin
          if (s_axi.wvalid) begin
            bresp_q <= worst_resp(bresp_q, worst_resp(wr_beat_resp,
                         (s_axi.wlast != wr_last) ? RESP_SLVERR : RESP_OKAY));
            if (s_axi.wlast) begin
              bvalid_q <= 1'b1;
              state_q  <= StWrResp;
            end
          end
        end
        StWrResp: begin
          if (s_axi.bready) begin
            bvalid_q <= 1'b0;
            state_q  <= StIdle;
          end
        end
        StRdReq: state_q <= StRdCap;
        StRdCap: begin
          rdata_q  <= rd_ok ? mem_rdata : '0;
          rresp_q  <= rd_beat_resp;
          rlast_q  <= rd_last;
          rvalid_q <= 1'b1;
          state_q  <= StRdData;
        end
        StRdData: begin
          if (s_axi.rready) begin
            rvalid_q <= 1'b0;
            state_q  <= rlast_q ? StIdle : StRdReq;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
